tod_frame_parser: RTL and testbench
===================================

Name: tod_frame_parser

Overview:
- Upstream neighbour of the TOD timestamp block; sits between the UART byte receiver and the timestamp latch/checksum logic.
- Hunts for fixed-format TOD frames in the received byte stream, verifies each frame's XOR checksum, and stages the decoded time fields.
- Commits staged fields to its outputs on the next PPS rising edge, so the fields describe the second that PPS marks.
- Outputs feed the timestamp latch directly.

Parameters:
- HDR0, 8'h43, first header byte.
- HDR1, 8'h4D, second header byte.
- MSG_CLASS, 8'h01, required class byte.
- MSG_ID, 8'h01, required ID byte.
- PAYLOAD_LEN, 16, required payload length in bytes.
- BYTE_TIMEOUT, 125000, inter-byte gap in clk cycles (1 ms at 125 MHz) that aborts a frame.

Ports:
- clk_125m, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- pps, in, 1, PPS level, already synchronised to clk_125m.
- din, in, 8, received byte.
- din_vld, in, 1, one-cycle strobe qualifying din.
- week, out, 16, committed GPS week.
- week_sec, out, 32, committed seconds of week.
- leap_sec, out, 8, committed leap seconds.
- pps_state, out, 8, committed PPS state.
- timesrc_type, out, 8, committed time source type.
- pps_precision, out, 8, committed PPS precision.
- frame_ok, out, 1, one-cycle pulse when a frame passes all checks.
- frame_err, out, 1, one-cycle pulse when a frame is aborted or rejected.
- err_cnt, out, 16, count of frame_err pulses; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending=0, staging registers 0.
- Frame format, 23 bytes in order:
  - HDR0, HDR1, CLASS, ID, LEN_H, LEN_L.
  - Payload of 16 bytes: week[15:8], week[7:0], week_sec (4 bytes, MSB first), leap_sec, pps_state, timesrc_type, pps_precision, 6 reserved bytes (ignored).
  - CK: XOR of CLASS through the last payload byte.
- The FSM advances only on din_vld cycles. States:
  - IDLE: din==HDR0 goes to H1.
  - H1: din==HDR1 goes to HDR; din==HDR0 stays in H1; any other byte goes to IDLE with no error.
  - HDR: collects CLASS, ID, LEN (4 bytes). CLASS!=MSG_CLASS, ID!=MSG_ID or {LEN_H,LEN_L}!=PAYLOAD_LEN triggers frame_err and a return to IDLE on the byte that fails.
  - PAY: byte counter 0..15; bytes are written into staging shadow registers.
  - CK: din==running XOR copies shadow into staging, sets pending=1 and pulses frame_ok. A mismatch pulses frame_err. Both cases return to IDLE.
- Running XOR clears on entry to HDR and accumulates CLASS..last payload byte.
- Timeout: a gap counter clears on every din_vld. In any state other than IDLE, reaching BYTE_TIMEOUT-1 pulses frame_err and returns to IDLE. The counter holds while in IDLE.
- frame_ok and frame_err are registered and assert the cycle after the deciding byte's din_vld.
- PPS edge: pps_d <= pps; pps_rise = pps & ~pps_d.
  - In the cycle pps_rise is high with pending=1, outputs load staging (visible the next cycle) and pending clears.
  - With pending=0, outputs hold (see the optional feature).
- Simultaneous pps_rise and checksum-pass staging update: the commit uses the old staging contents and pending stays 1, so the new frame commits at the next PPS.
- A second good frame before PPS overwrites staging; only the latest commits.
- err_cnt increments by 1 per frame_err and holds at 16'hFFFF.
- A reset mid-frame discards the partial frame, with no frame_err.

Optional Feature:
- Macro: TOD_AUTO_INC_EN.
- Defined: on pps_rise with pending=0, the outputs free-run:
  - week_sec increments by 1.
  - If week_sec was 604799, week_sec goes to 0 and week increments by 1 (16-bit wrap).
  - Other fields hold.
- Undefined: outputs hold on pps_rise with pending=0.

Test Plan:
- Good frame with week=16'h08A5, week_sec=32'h0001_E240, leap=18, state=1, type=2, prec=3, then a PPS rise -> frame_ok once; outputs unchanged before PPS and equal to the frame values one cycle after pps_rise; err_cnt=0.
- Same frame with CK XOR 8'h01 -> frame_err once; err_cnt=1; outputs unchanged at the next PPS (macro undefined).
- Bytes 43 43 4D followed by a valid remainder -> resync in H1; frame_ok asserts.
- 10 bytes of a frame, then a 125000-cycle gap -> frame_err exactly 125000 cycles after the last din_vld; next valid frame accepted.
- frame_ok-producing byte coincident with pps_rise while frame A is pending and frame B arrives -> frame A committed; frame B committed at the following PPS.
- With TOD_AUTO_INC_EN: commit week_sec=604799, week=5, then a PPS with no frame -> week_sec=0, week=6.

Source files
------------

// File: rtl/tod_frame_parser.sv
// TOD frame parser: hunts, checks and stages TOD frames; commits on PPS rise.
// Optional TOD_AUTO_INC_EN: free-run week_sec on PPS when nothing is pending.
module tod_frame_parser #(
    parameter logic [7:0] HDR0         = 8'h43,
    parameter logic [7:0] HDR1         = 8'h4D,
    parameter logic [7:0] MSG_CLASS    = 8'h01,
    parameter logic [7:0] MSG_ID       = 8'h01,
    parameter int         PAYLOAD_LEN  = 16,
    parameter int         BYTE_TIMEOUT = 125000
) (
    input  logic        clk_125m,
    input  logic        rst_n,
    input  logic        pps,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [15:0] week,
    output logic [31:0] week_sec,
    output logic [7:0]  leap_sec,
    output logic [7:0]  pps_state,
    output logic [7:0]  timesrc_type,
    output logic [7:0]  pps_precision,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] err_cnt
);

    localparam int              GW      = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [GW-1:0]   GAP_LIM = GW'(BYTE_TIMEOUT - 1);
    localparam logic [15:0]     PLEN    = 16'(PAYLOAD_LEN);
    localparam logic [4:0]      PAY_END = 5'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_H1, S_HDR, S_PAY, S_CK} state_t;

    state_t        state, nxt;
    logic [4:0]    cnt;
    logic [7:0]    xsum;
    logic [79:0]   shadow, stage, tod;
    logic          pending, pps_d, pps_rise;
    logic [GW-1:0] gap;
    logic          hdr_bad, timeout, ck_pass, ok_set, err_set;

    assign pps_rise = pps & ~pps_d;
    assign timeout  = (state != S_IDLE) && !din_vld && (gap == GAP_LIM);
    assign ck_pass  = (state == S_CK) && din_vld && (din == xsum);

    // Header field check for the byte currently in the HDR phase
    always_comb begin
        hdr_bad = 1'b0;
        unique case (cnt[1:0])
            2'd0:    hdr_bad = (din != MSG_CLASS);
            2'd1:    hdr_bad = (din != MSG_ID);
            2'd2:    hdr_bad = (din != PLEN[15:8]);
            default: hdr_bad = (din != PLEN[7:0]);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // FSM next state: advances on din_vld, aborts on inter-byte timeout
    always_comb begin
        nxt = state;
        if (timeout) begin
            nxt = S_IDLE;
        end else if (din_vld) begin
            unique case (state)
                S_IDLE: if (din == HDR0) nxt = S_H1;
                S_H1: begin
                    if (din == HDR1)      nxt = S_HDR;
                    else if (din == HDR0) nxt = S_H1;
                    else                  nxt = S_IDLE;
                end
                S_HDR: begin
                    if (hdr_bad)         nxt = S_IDLE;
                    else if (cnt == 5'd3) nxt = S_PAY;
                end
                S_PAY: if (cnt == PAY_END) nxt = S_CK;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs: frame verdicts, registered below
    always_comb begin
        ok_set  = ck_pass;
        err_set = timeout;
        if (din_vld && state == S_HDR && hdr_bad)    err_set = 1'b1;
        if (din_vld && state == S_CK && din != xsum) err_set = 1'b1;
    end

    // Byte counter and running checksum over CLASS..last payload byte
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            xsum <= '0;
        end else if (din_vld) begin
            unique case (state)
                S_H1: begin
                    cnt  <= '0;
                    xsum <= '0;
                end
                S_HDR: begin
                    cnt  <= (cnt == 5'd3) ? 5'd0 : cnt + 5'd1;
                    xsum <= xsum ^ din;
                end
                S_PAY: begin
                    cnt  <= cnt + 5'd1;
                    xsum <= xsum ^ din;
                end
                default: ;
            endcase
        end
    end

    // Shadow capture: first ten payload bytes shift in MSB first
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (din_vld && state == S_PAY && cnt < 5'd10)
            shadow <= {shadow[71:0], din};
    end

    // PPS edge detector
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) pps_d <= 1'b0;
        else        pps_d <= pps;
    end

    // Staging, pending flag and committed time; commit uses pre-update staging
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            stage   <= '0;
            pending <= 1'b0;
            tod     <= '0;
        end else begin
            if (ck_pass) begin
                stage   <= shadow;
                pending <= 1'b1;
            end else if (pps_rise) begin
                pending <= 1'b0;
            end
            if (pps_rise && pending) begin
                tod <= stage;
            end
`ifdef TOD_AUTO_INC_EN
            else if (pps_rise) begin
                if (tod[63:32] == 32'd604799) begin
                    tod[63:32] <= '0;
                    tod[79:64] <= tod[79:64] + 16'd1;
                end else begin
                    tod[63:32] <= tod[63:32] + 32'd1;
                end
            end
`endif
        end
    end

    // Verdict pulses and saturating error counter
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_ok  <= ok_set;
            frame_err <= err_set;
            if (err_set && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

    // Inter-byte gap counter: cleared by each byte, frozen while idle
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n)                gap <= '0;
        else if (din_vld)          gap <= '0;
        else if (state != S_IDLE)  gap <= gap + 1'b1;
    end

    assign week          = tod[79:64];
    assign week_sec      = tod[63:32];
    assign leap_sec      = tod[31:24];
    assign pps_state     = tod[23:16];
    assign timesrc_type  = tod[15:8];
    assign pps_precision = tod[7:0];

endmodule

// File: tb/tb_tod_frame_parser.sv
// Randomised bench for tod_frame_parser against a frame-level model.
// Timeout is shortened via BYTE_TIMEOUT to keep run time small.
module tb_tod_frame_parser;

    localparam int TO = 200;

    logic        clk_125m = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps = 1'b0;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0;
    logic [15:0] week;
    logic [31:0] week_sec;
    logic [7:0]  leap_sec, pps_state, timesrc_type, pps_precision;
    logic        frame_ok, frame_err;
    logic [15:0] err_cnt;

    tod_frame_parser #(.BYTE_TIMEOUT(TO)) dut (
        .clk_125m(clk_125m), .rst_n(rst_n), .pps(pps),
        .din(din), .din_vld(din_vld),
        .week(week), .week_sec(week_sec), .leap_sec(leap_sec),
        .pps_state(pps_state), .timesrc_type(timesrc_type),
        .pps_precision(pps_precision),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #4 clk_125m = ~clk_125m;

    logic [79:0] tod_o;
    assign tod_o = {week, week_sec, leap_sec, pps_state,
                    timesrc_type, pps_precision};

    int n_tests = 0;
    int n_fail  = 0;
    int ok_seen = 0;
    int err_seen = 0;

    // model state
    logic [79:0] m_tod = '0;
    logic [79:0] m_stage = '0;
    bit          m_pend = 0;
    int          m_err = 0;

    always @(posedge clk_125m) begin
        if (rst_n) begin
            ok_seen  += int'(frame_ok);
            err_seen += int'(frame_err);
        end
    end

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_pps();
        logic [15:0] wk;
        logic [31:0] ws;
        if (m_pend) begin
            m_tod  = m_stage;
            m_pend = 0;
        end else begin
`ifdef TOD_AUTO_INC_EN
            wk = m_tod[79:64];
            ws = m_tod[63:32];
            if (ws + 1 == 604800) begin
                ws = 0;
                wk = wk + 1;
            end else begin
                ws = ws + 1;
            end
            m_tod[79:64] = wk;
            m_tod[63:32] = ws;
`else
            wk = '0;
            ws = '0;
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk_125m);
        din = b;
        din_vld = 1'b1;
        @(negedge clk_125m);
        din_vld = 1'b0;
        din = '0;
        repeat (gap) @(negedge clk_125m);
    endtask

    task automatic pps_pulse(input string tag);
        @(negedge clk_125m);
        pps = 1'b1;
        @(negedge clk_125m);
        model_pps();
        check(tag, tod_o, m_tod);
        pps = 1'b0;
        repeat (2) @(negedge clk_125m);
    endtask

    function automatic logic [79:0] rnd_fields();
        logic [79:0] f;
        f[79:64] = 16'($urandom);
        f[63:32] = $urandom_range(0, 604799);
        f[31:0]  = $urandom;
        return f;
    endfunction

    // kind: 0 good, 1 bad CK, 2 bad class, 3 bad id, 4 bad length
    task automatic send_frame(input string tag, input logic [79:0] f,
                              input int kind, input bit pre43,
                              input bit pps_at_ck);
        logic [7:0] q[$];
        logic [7:0] body[$];
        logic [7:0] x, b;
        int ok0, err0, n, last;
        ok0  = ok_seen;
        err0 = err_seen;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'h4D) b = 8'h00;
            q.push_back(b);
        end
        if (pre43) q.push_back(8'h43);
        q.push_back(8'h43);
        q.push_back(8'h4D);
        body = '{8'h01, 8'h01, 8'h00, 8'h10};
        if (kind >= 2) begin
            b = 8'($urandom_range(1, 255));
            body[kind-2] = body[kind-2] ^ b;
        end
        for (int i = 0; i < 10; i++) body.push_back(f[79-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(8'($urandom));
        x = '0;
        foreach (body[i]) x ^= body[i];
        if (kind == 1) x ^= 8'h01;
        if (kind >= 2) begin
            last = kind - 2;
        end else begin
            last = body.size();
            body.push_back(x);
        end
        for (int i = 0; i <= last; i++) q.push_back(body[i]);
        for (int i = 0; i < q.size() - 1; i++)
            send_byte(q[i], $urandom_range(0, 3));
        @(negedge clk_125m);
        din = q[q.size()-1];
        din_vld = 1'b1;
        if (pps_at_ck) pps = 1'b1;
        @(negedge clk_125m);
        din_vld = 1'b0;
        if (pps_at_ck) begin
            model_pps();
            check({tag, "_ppsck"}, tod_o, m_tod);
        end
        if (kind == 0) begin
            m_stage = f;
            m_pend  = 1;
        end else begin
            m_err++;
        end
        repeat (3) @(negedge clk_125m);
        pps = 1'b0;
        check({tag, "_ok"}, 80'(ok_seen - ok0), 80'(kind == 0));
        check({tag, "_err"}, 80'(err_seen - err0), 80'(kind != 0));
        check({tag, "_cnt"}, 80'(err_cnt), 80'(m_err));
        check({tag, "_hold"}, tod_o, m_tod);
    endtask

    initial begin
        logic [79:0] fa, fb;
        int err0;
        repeat (3) @(negedge clk_125m);
        check("rst_tod", tod_o, 80'h0);
        check("rst_flags", {78'h0, frame_ok, frame_err}, 80'h0);
        check("rst_cnt", 80'(err_cnt), 80'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_125m);

        fa = {16'h08A5, 32'h0001_E240, 8'd18, 8'd1, 8'd2, 8'd3};
        send_frame("good", fa, 0, 0, 0);
        pps_pulse("good_commit");
        send_frame("badck", fa, 1, 0, 0);
        pps_pulse("badck_pps");
        send_frame("resync", rnd_fields(), 0, 1, 0);
        pps_pulse("resync_commit");

        // timeout after ten bytes
        fb = rnd_fields();
        err0 = err_seen;
        send_byte(8'h43, 1); send_byte(8'h4D, 1);
        send_byte(8'h01, 1); send_byte(8'h01, 1);
        send_byte(8'h00, 1); send_byte(8'h10, 1);
        for (int i = 0; i < 4; i++) send_byte(fb[79-8*i -: 8], i == 3 ? 0 : 1);
        repeat (TO - 1) @(negedge clk_125m);
        check("to_early", {79'h0, frame_err}, 80'h0);
        @(negedge clk_125m);
        check("to_exact", {79'h0, frame_err}, 80'h1);
        m_err++;
        repeat (2) @(negedge clk_125m);
        check("to_once", 80'(err_seen - err0), 80'h1);
        check("to_cnt", 80'(err_cnt), 80'(m_err));
        send_frame("after_to", fb, 0, 0, 0);
        pps_pulse("after_to_commit");

        // checksum byte coincident with PPS while an earlier frame pends
        send_frame("coA", rnd_fields(), 0, 0, 0);
        send_frame("coB", rnd_fields(), 0, 0, 1);
        pps_pulse("coB_commit");

        // week rollover in free-run mode (hold otherwise)
        send_frame("roll", {16'd5, 32'd604799, 32'h12_01_02_03}, 0, 0, 0);
        pps_pulse("roll_commit");
        pps_pulse("roll_next");
        pps_pulse("roll_next2");

        for (int it = 0; it < 25; it++) begin
            int k;
            k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            send_frame("rnd", rnd_fields(), k, 1'($urandom_range(0, 1)),
                       (k == 0) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) pps_pulse("rnd_pps");
        end
        pps_pulse("rnd_final");

        // reset mid-frame discards the partial frame silently
        fb = rnd_fields();
        send_frame("pre_rst", fb, 0, 0, 0);
        send_byte(8'h43, 0); send_byte(8'h4D, 0);
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        @(negedge clk_125m);
        rst_n = 1'b0;
        @(negedge clk_125m);
        rst_n = 1'b1;
        m_tod = '0; m_stage = '0; m_pend = 0; m_err = 0;
        err0 = err_seen;
        repeat (3) @(negedge clk_125m);
        check("mrst_err", 80'(err_seen - err0), 80'h0);
        check("mrst_tod", tod_o, 80'h0);
        check("mrst_cnt", 80'(err_cnt), 80'h0);
        pps_pulse("mrst_pps");
        send_frame("post_rst", rnd_fields(), 0, 0, 0);
        pps_pulse("post_rst_commit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
